// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// ALU/PC select codes and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RDEXEC = 4'd6,
    S_RDWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  // States that own the memory port and may stall on mem_ready.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  function automatic logic op_supported(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control map with mem_ready gating, abort suppression
// and reset force-to-zero.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic   i_rst,
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_illegal,
  input  logic   i_timeout,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_FOUR;
        o_ctrl.irwrite = i_mem_ready;
        o_ctrl.pcwrite = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alusrcb    = ALUSRCB_IMMSH;
        o_ctrl.illegal_op = i_illegal;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.memtoreg   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.memwrite   = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_RDEXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RDWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.regdst     = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca     = 1'b1;
        o_ctrl.aluop       = ALUOP_SUB;
        o_ctrl.pcwritecond = 1'b1;
        o_ctrl.pcsource    = PCSRC_ALUOUT;
        o_ctrl.instr_done  = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pcwrite    = 1'b1;
        o_ctrl.pcsource   = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
    // An aborted wait must leave architectural state untouched.
    if (i_timeout) begin
      o_ctrl.pcwrite     = 1'b0;
      o_ctrl.pcwritecond = 1'b0;
      o_ctrl.irwrite     = 1'b0;
      o_ctrl.regwrite    = 1'b0;
      o_ctrl.memwrite    = 1'b0;
      o_ctrl.mem_timeout = 1'b1;
    end
    if (i_rst) o_ctrl = '0;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller: state register, next-state logic
// and memory wait counter; output map lives in multicycle_ctrl_decode.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 0,
  parameter int WAIT_CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [WAIT_CNT_W-1:0] LP_WAIT_MAX = WAIT_CNT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] LP_ONE      = WAIT_CNT_W'(1);

  state_t                r_state;
  state_t                w_next;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  w_mem_state;
  logic                  w_timeout;
  logic                  w_illegal;
  ctrl_t                 w_ctrl;

  assign w_mem_state = is_mem_state(r_state);
  assign w_timeout   = (MEM_WAIT_MAX != 0) && w_mem_state && !mem_ready &&
                       (r_wait_cnt == LP_WAIT_MAX);
  assign w_illegal   = !op_supported(op);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RDEXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RDEXEC: w_next = S_RDWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
    if (w_timeout) w_next = S_FETCH;
  end

  // Any state change (or a timeout re-entering FETCH) is an entry, which
  // restarts the wait count; only a stalled memory state accumulates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_timeout) begin
        r_wait_cnt <= '0;
      end else if (w_mem_state && !mem_ready && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + LP_ONE;
      end
    end
  end

  multicycle_ctrl_decode u_decode (
    .i_rst       (rst),
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_illegal   (w_illegal),
    .i_timeout   (w_timeout),
    .o_ctrl      (w_ctrl)
  );

  assign pcwrite     = w_ctrl.pcwrite;
  assign pcwritecond = w_ctrl.pcwritecond;
  assign iord        = w_ctrl.iord;
  assign memread     = w_ctrl.memread;
  assign memwrite    = w_ctrl.memwrite;
  assign irwrite     = w_ctrl.irwrite;
  assign memtoreg    = w_ctrl.memtoreg;
  assign regdst      = w_ctrl.regdst;
  assign regwrite    = w_ctrl.regwrite;
  assign alusrca     = w_ctrl.alusrca;
  assign alusrcb     = w_ctrl.alusrcb;
  assign aluop       = w_ctrl.aluop;
  assign pcsource    = w_ctrl.pcsource;
  assign instr_done  = w_ctrl.instr_done;
  assign illegal_op  = w_ctrl.illegal_op;
  assign mem_timeout = w_ctrl.mem_timeout;
  assign state       = rst ? 4'(S_FETCH) : 4'(r_state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: an instruction-step model checks
// every cycle, plus hand-computed literal expectations per scenario.
module tb_multicycle_control_fsm;

  localparam int MAXW = 4;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = LW;
  logic       mem_ready = 1'b1;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;
  logic       instr_done, illegal_op, mem_timeout;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_fsm #(.MEM_WAIT_MAX(MAXW), .WAIT_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  // Model: position within the current instruction plus the wait count.
  int         m_step = 0;
  int         m_wait = 0;
  logic [5:0] m_op = '0;

  function automatic bit legal(logic [5:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == JMP) || (o == ADDI);
  endfunction

  function automatic int seq_len(logic [5:0] o);
    case (o)
      LW:            return 5;
      SW, RT, ADDI:  return 4;
      BEQ, JMP:      return 3;
      default:       return 2;
    endcase
  endfunction

  function automatic int exp_state(int step, logic [5:0] o);
    if (step == 0) return 0;
    if (step == 1) return 1;
    case (o)
      LW:      return step;
      SW:      return (step == 2) ? 2 : 5;
      RT:      return (step == 2) ? 6 : 7;
      BEQ:     return 8;
      JMP:     return 9;
      ADDI:    return (step == 2) ? 10 : 11;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_mem(int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic logic [19:0] exp_vec(int s, bit rdy, logic [5:0] o, bit tmo);
    bit pcw = 0, pcwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
    bit m2r = 0, rdst = 0, rw = 0, asa = 0, done = 0, ill = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'b11; ill = !legal(o); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mwr = 1; io = 1; done = rdy; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; done = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
      9:  begin pcw = 1; psrc = 2'b10; done = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    if (tmo) begin pcw = 0; pcwc = 0; irw = 0; rw = 0; mwr = 0; end
    return {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill, tmo};
  endfunction

  initial begin
    int es;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_step = 0;
        m_wait = 0;
      end else begin
        es = exp_state(m_step, m_op);
        if (is_mem(es) && !mem_ready) begin
          if (MAXW != 0 && m_wait == MAXW) begin
            m_step = 0;
            m_wait = 0;
          end else if (m_wait < 255) begin
            m_wait++;
          end
        end else begin
          m_wait = 0;
          if (m_step == 1) begin
            m_op   = op;
            m_step = legal(op) ? 2 : 0;
          end else if (m_step >= seq_len(m_op) - 1) begin
            m_step = 0;
          end else begin
            m_step++;
          end
        end
      end
    end
  end

  initial begin
    int es;
    bit tmo;
    logic [19:0] ev, av;
    forever begin
      @(negedge clk);
      if (rst) begin
        es = 0;
        ev = '0;
      end else begin
        es  = exp_state(m_step, m_op);
        tmo = is_mem(es) && !mem_ready && (MAXW != 0) && (m_wait == MAXW);
        ev  = exp_vec(es, mem_ready, op, tmo);
      end
      av = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
            regwrite, alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op, mem_timeout};
      n_checks += 2;
      if (state !== 4'(es)) begin
        n_errors++;
        $display("FAIL model_state t=%0t: got %0d expected %0d", $time, state, es);
      end
      if (av !== ev) begin
        n_errors++;
        $display("FAIL model_outputs t=%0t state=%0d: got %05h expected %05h", $time, es, av, ev);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic [5:0] o, input logic r);
    @(posedge clk);
    #2;
    rst = 1'b0;
    op = o;
    mem_ready = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int lw_st[5] = '{0, 1, 2, 3, 4};
    logic [5:0] b2b_op[4] = '{BEQ, JMP, RT, ADDI};
    int b2b_len[4] = '{3, 3, 4, 4};
    int b2b_st[4] = '{8, 9, 7, 11};
    int n;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_memread", memread, 0);
    chk("rst_irwrite", irwrite, 0);
    chk("rst_pcwrite", pcwrite, 0);

    for (int i = 0; i < 5; i++) begin
      cyc(LW, 1'b1);
      chk("lw_state", state, lw_st[i]);
      chk("lw_memread", memread, (i == 0) || (i == 3));
      chk("lw_regwrite", regwrite, i == 4);
      chk("lw_memtoreg", memtoreg, i == 4);
      chk("lw_done", instr_done, i == 4);
    end

    for (int i = 0; i < 3; i++) begin
      cyc(SW, 1'b1);
      chk("sw_state", state, i);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(SW, 1'b0);
      chk("sw_wait_state", state, 5);
      chk("sw_wait_memwrite", memwrite, 1);
      chk("sw_wait_iord", iord, 1);
      chk("sw_wait_done", instr_done, 0);
      chk("sw_wait_regwrite", regwrite, 0);
    end
    cyc(SW, 1'b1);
    chk("sw_last_state", state, 5);
    chk("sw_last_memwrite", memwrite, 1);
    chk("sw_last_done", instr_done, 1);

    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        cyc(b2b_op[k], 1'b1);
        n++;
      end while (!instr_done && n < 10);
      chk("b2b_latency", n, b2b_len[k]);
      chk("b2b_done_state", state, b2b_st[k]);
      chk("b2b_pcwritecond", pcwritecond, k == 0);
      chk("b2b_jump_pcsource", pcsource == 2'b10, k == 1);
      chk("b2b_regdst", regdst, k == 2);
    end

    cyc(BAD, 1'b1);
    chk("ill_fetch_state", state, 0);
    cyc(BAD, 1'b1);
    chk("ill_decode_state", state, 1);
    chk("ill_pulse", illegal_op, 1);
    chk("ill_regwrite", regwrite, 0);
    chk("ill_pcwrite", pcwrite, 0);
    cyc(LW, 1'b1);
    chk("ill_refetch_state", state, 0);
    chk("ill_pulse_gone", illegal_op, 0);

    cyc(LW, 1'b1);
    chk("to_decode_state", state, 1);
    cyc(LW, 1'b1);
    chk("to_memadr_state", state, 2);
    for (int i = 0; i < 5; i++) begin
      cyc(LW, 1'b0);
      chk("to_wait_state", state, 3);
      chk("to_memread", memread, 1);
      chk("to_pulse", mem_timeout, i == 4);
      chk("to_regwrite", regwrite, 0);
    end
    cyc(LW, 1'b0);
    chk("to_after_state", state, 0);
    chk("to_after_irwrite", irwrite, 0);

    cyc(RT, 1'b1);
    chk("rr_fetch_irwrite", irwrite, 1);
    cyc(RT, 1'b1);
    chk("rr_decode_state", state, 1);
    cyc(RT, 1'b1);
    chk("rr_exec_state", state, 6);
    #1;
    rst = 1'b1;
    #1;
    chk("rr_rst_state", state, 0);
    chk("rr_rst_alusrca", alusrca, 0);
    chk("rr_rst_aluop", aluop, 0);
    chk("rr_rst_all", {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                       regdst, regwrite, alusrca, alusrcb, aluop, pcsource, instr_done,
                       illegal_op, mem_timeout}, 0);
    cyc(ADDI, 1'b1);
    chk("rr_after_state", state, 0);
    chk("rr_after_regwrite", regwrite, 0);
    chk("rr_after_memread", memread, 1);
    cyc(ADDI, 1'b1);
    chk("addi_decode_state", state, 1);
    cyc(ADDI, 1'b1);
    chk("addi_ex_state", state, 10);
    cyc(ADDI, 1'b1);
    chk("addi_wb_state", state, 11);
    chk("addi_wb_regwrite", regwrite, 1);
    chk("addi_wb_regdst", regdst, 0);

    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multi-cycle variant of the MIPS datapath. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback, driving one shared ALU, one shared memory port and the register file. It supports R-type, lw, sw, beq, addi and j, and stalls on a memory ready handshake. It replaces the single-cycle opcode decoder when the core is built in multi-cycle mode.

Parameters:
MEM_WAIT_MAX, 0, maximum cycles to wait for mem_ready in a memory state; 0 means wait forever.
WAIT_CNT_W, 8, width of the memory wait counter; MEM_WAIT_MAX must be less than 2^WAIT_CNT_W.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
op  in  6  opcode from the instruction register (IR[31:26])
mem_ready  in  1  memory completes the current access this cycle
pcwrite  out  1  unconditional PC load
pcwritecond  out  1  PC load if ALU zero (beq)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
memtoreg  out  1  register write data select: 1 = MDR, 0 = ALUOut
regdst  out  1  destination register select: 1 = rd, 0 = rt
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
aluop  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct field
pcsource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse on the last cycle of each retired instruction
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
mem_timeout  out  1  one-cycle pulse when a memory wait is aborted
state  out  4  current state, for debug only

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high: with rst high at a rising edge, state becomes FETCH and the wait counter clears.
- Outputs during reset: while rst is high, every output strobe, enable and pulse is forced to 0 combinationally. Selects are 0 and state reads FETCH.
- Output style: all outputs are Moore functions of state, except the mem_ready gating below. Any output not listed for a state is 0.
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RDEXEC=6, RDWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12-15 are unreachable and go to FETCH on the next edge.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. irwrite and pcwrite equal mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> RDEXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> FETCH, with illegal_op=1 in the DECODE cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1. Go to FETCH.
- MEMWR: memwrite=1, iord=1. instr_done equals mem_ready. Wait for mem_ready, then go to FETCH.
- RDEXEC: alusrca=1, alusrcb=00, aluop=10. Go to RDWB.
- RDWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, instr_done=1. Go to FETCH.
- JUMP: pcwrite=1, pcsource=10, instr_done=1. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Go to FETCH.
- Strobe stability: memread, memwrite and iord stay constant for every cycle of a memory wait. memwrite is never high in the same cycle as memread.
- Latency with mem_ready always 1: beq 3 cycles, j 3, R-type 4, addi 4, sw 4, lw 5.
- Wait counter:
  - Clears on entry to each of FETCH, MEMRD and MEMWR.
  - Increments in each cycle a memory state sees mem_ready=0, saturating at its maximum.
  - If MEM_WAIT_MAX is nonzero and the counter equals MEM_WAIT_MAX while mem_ready=0: pulse mem_timeout, suppress every write enable that cycle, and go to FETCH. The PC is unchanged, so the instruction is re-fetched.
- op is sampled only in DECODE and MEMADR. The datapath holds IR stable between FETCH completion and the next FETCH.
- Reset mid-instruction: the instruction is abandoned at the reset edge with no further writes, and execution restarts at FETCH.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - the state enum
  - ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - ALUSRCB_* and PCSRC_* encodings
- One sub-module, multicycle_ctrl_decode: purely combinational state-to-output map, including the mem_ready gating and the reset force-to-zero.
- The FSM register, next-state logic and wait counter live in the top module.

Test Plan:
- Reset then lw (op=100011), mem_ready=1 -> states 0,1,2,3,4; memread high in cycles 1 and 4; regwrite=memtoreg=1 only in cycle 5; instr_done once; repeats from FETCH.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite and iord held high 4 cycles; instr_done only in the final cycle; regwrite never high.
- beq, j, R-type and addi back-to-back, mem_ready=1 -> retire in 3, 3, 4 and 4 cycles; pcwritecond only in BRANCH; pcsource=10 only in JUMP; regdst=1 only in RDWB.
- op=111111 -> illegal_op pulses in the DECODE cycle; FETCH the next cycle; no regwrite, memwrite or pcwrite beyond the fetch.
- MEM_WAIT_MAX=4, mem_ready stuck low in MEMRD -> mem_timeout in the 5th wait cycle, then FETCH; regwrite never high.
- rst asserted in RDEXEC -> all strobes 0 while rst is high; state=FETCH one cycle after the reset edge; no RDWB write.
